// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller.
// Holds the controller state encoding, the per-phase light codes
// and a small helper used to size the dwell timer.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED,
    ST_GO,
    ST_WAIT,
    ST_PED_WALK,
    ST_FLASH
  } state_t;

  // Per-phase light codes, bit order {red, yellow, green}
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running timing tick generator.
// Produces a one-clk tick every DIVISOR clocks; the first tick after
// reset lands on the DIVISOR-th clock.
module tick_gen #(
  parameter int DIVISOR = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] count;

  // Count 0..DIVISOR-1 and wrap; never paused by controller state
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-phase traffic signal controller.
// Cycles the approaches round-robin with an all-red clearance between
// them, inserts a walk interval when a pedestrian request is pending,
// and falls back to flashing yellow while a fault is present.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 4,
  parameter int NUM_PHASES   = 2,
  parameter int GO_TICKS     = 24,
  parameter int WAIT_TICKS   = 12,
  parameter int ALLRED_TICKS = 4,
  parameter int PED_TICKS    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    go_extend,
  input  logic                          ped_req,
  input  logic                          fault,
  output logic [3*NUM_PHASES-1:0]       lights,
  output logic                          ped_walk,
  output logic                          ped_ack,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx
);

  localparam int DIVISOR   = CLK_HZ / TICK_HZ;
  localparam int PW        = $clog2(NUM_PHASES);
  // Timer must hold the longest dwell, including a fully extended green
  localparam int TIMER_MAX = max_int(max_int(GO_TICKS + 15, WAIT_TICKS),
                                     max_int(ALLRED_TICKS, PED_TICKS));
  localparam int TW        = $clog2(TIMER_MAX + 1);

  logic          tick;
  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [PW-1:0] phase_next;
  logic          ped_pending, pending_next;
  logic          flash_yellow, flash_next;
  logic          ack_next;

  tick_gen #(
    .DIVISOR (DIVISOR)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Register the controller state, dwell timer, phase and pedestrian latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ALL_RED;
      timer        <= TW'(ALLRED_TICKS);
      phase_idx    <= '0;
      ped_pending  <= 1'b0;
      flash_yellow <= 1'b0;
      ped_ack      <= 1'b0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      phase_idx    <= phase_next;
      ped_pending  <= pending_next;
      flash_yellow <= flash_next;
      ped_ack      <= ack_next;
    end
  end

  // Next-state logic: fault overrides everything, otherwise advance on tick
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    phase_next   = phase_idx;
    pending_next = ped_pending | (ped_req && (state != ST_PED_WALK));
    flash_next   = flash_yellow;
    ack_next     = 1'b0;

    if (fault) begin
      state_next = ST_FLASH;
      flash_next = (state != ST_FLASH) ? 1'b1 : (flash_yellow ^ tick);
    end else if (state == ST_FLASH) begin
      state_next   = ST_ALL_RED;
      timer_next   = TW'(ALLRED_TICKS);
      phase_next   = '0;
      pending_next = 1'b0;
    end else if (tick) begin
      if (timer == TW'(1)) begin
        case (state)
          ST_ALL_RED: begin
            if (ped_pending) begin
              state_next   = ST_PED_WALK;
              timer_next   = TW'(PED_TICKS);
              pending_next = 1'b0;
              ack_next     = 1'b1;
            end else begin
              state_next = ST_GO;
              timer_next = TW'(GO_TICKS) + TW'(go_extend);
            end
          end
          ST_GO: begin
            state_next = ST_WAIT;
            timer_next = TW'(WAIT_TICKS);
          end
          ST_WAIT: begin
            state_next = ST_ALL_RED;
            timer_next = TW'(ALLRED_TICKS);
            phase_next = (phase_idx == PW'(NUM_PHASES - 1)) ? '0 : phase_idx + 1'b1;
          end
          default: begin
            state_next = ST_ALL_RED;
            timer_next = TW'(ALLRED_TICKS);
          end
        endcase
      end else begin
        timer_next = timer - 1'b1;
      end
    end
  end

  // Decode the light pattern and walk lamp from registered state only
  always_comb begin
    lights   = '0;
    ped_walk = (state == ST_PED_WALK);
    for (int i = 0; i < NUM_PHASES; i++) begin
      case (state)
        ST_FLASH: lights[3*i +: 3] = flash_yellow ? LIGHT_YELLOW : LIGHT_OFF;
        ST_GO:    lights[3*i +: 3] = (phase_idx == PW'(i)) ? LIGHT_GREEN : LIGHT_RED;
        ST_WAIT:  lights[3*i +: 3] = (phase_idx == PW'(i)) ? LIGHT_YELLOW : LIGHT_RED;
        default:  lights[3*i +: 3] = LIGHT_RED;
      endcase
    end
  end

endmodule
